sram_port_arbiter: RTL and testbench

Shares the single-port synchronous SRAM between the instruction-fetch requester and the load/store requester of the CPU core. Each cycle it grants at most one request. It drives the SRAM port from the granted requester and routes the read data or write acknowledge back one cycle later. Data accesses take priority, and a starvation counter guarantees forward progress for fetch. The block sits between `mycpu_top`'s fetch and memory stages and the SRAM macro.

---
 rtl/sram_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// sram_port_arbiter
//
// Shares one single-port synchronous SRAM between the instruction-fetch
// requester and the load/store requester. The arbiter grants at most one
// request per cycle. It drives the SRAM port from the winner and routes the
// response (read data or store acknowledge) back to that requester one cycle
// later.
//
// Data accesses normally win. A saturating starvation counter forces a fetch
// through after STARVE_MAX consecutive cycles in which fetch lost to data.
//
// Parameters
//   STARVE_MAX   consecutive fetch denials tolerated before fetch wins (1..15)
//
// Ports
//   clk, resetn                      clock (rising edge), async active-low reset
//   inst_req / inst_addr             fetch request
//   inst_addr_ok                     fetch request accepted this cycle
//   inst_data_ok / inst_rdata        fetch response (one cycle after accept)
//   data_req / data_wr / data_wstrb
//   data_addr / data_wdata           load/store request
//   data_addr_ok                     load/store request accepted this cycle
//   data_data_ok / data_rdata        load data or store completion
//   sram_en / sram_we / sram_addr
//   sram_wdata                       SRAM command port
//   sram_rdata                       SRAM read data, valid one cycle after a read
// ============================================================================
module sram_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    // Owner of the response returning on the current cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } resp_state_t;

    resp_state_t r_resp_state;
    resp_state_t w_resp_state_nxt;

    logic [3:0]  r_starve_cnt;
    logic [3:0]  w_starve_cnt_nxt;

    logic        w_force_inst;
    logic        w_inst_gnt;
    logic        w_data_gnt;

    // ------------------------------------------------------------------
    // Grant decision: combinational from current requests and registered
    // state. Grants are qualified with resetn. This keeps addr_ok, sram_en
    // and sram_we low for the whole reset period, not only after the first
    // edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_force_inst = (r_starve_cnt == LP_STARVE_MAX);
        w_inst_gnt   = resetn && inst_req && (!data_req || w_force_inst);
        w_data_gnt   = resetn && data_req && !(inst_req && w_force_inst);
    end

    // ------------------------------------------------------------------
    // SRAM command port, driven from the granted requester. A fetch never
    // writes. A load drives zero byte enables but still forwards its wdata.
    // ------------------------------------------------------------------
    always_comb begin
        sram_en    = w_inst_gnt || w_data_gnt;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_inst_gnt) begin
            sram_addr = inst_addr;
        end else if (w_data_gnt) begin
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
            if (data_wr) begin
                sram_we = data_wstrb;
            end
        end
    end

    assign inst_addr_ok = w_inst_gnt;
    assign data_addr_ok = w_data_gnt;

    // ------------------------------------------------------------------
    // Starvation counter. It counts cycles in which a waiting fetch lost to
    // data, and saturates at STARVE_MAX. It clears as soon as the fetch is
    // served or stops requesting. A withdrawn fetch therefore keeps no credit.
    // ------------------------------------------------------------------
    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (!inst_req || w_inst_gnt) begin
            w_starve_cnt_nxt = '0;
        end else if (w_data_gnt && (r_starve_cnt < LP_STARVE_MAX)) begin
            w_starve_cnt_nxt = r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Response owner FSM. The SRAM has a fixed one-cycle read latency, so
    // the owner of next cycle's response is simply whoever wins this cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp_state <= IDLE;
        end else begin
            r_resp_state <= w_resp_state_nxt;
        end
    end

    always_comb begin
        w_resp_state_nxt = IDLE;
        inst_data_ok     = 1'b0;
        data_data_ok     = 1'b0;

        if (w_inst_gnt) begin
            w_resp_state_nxt = INST;
        end else if (w_data_gnt) begin
            w_resp_state_nxt = DATA;
        end

        case (r_resp_state)
            INST:    inst_data_ok = 1'b1;
            DATA:    data_data_ok = 1'b1;
            default: begin
                inst_data_ok = 1'b0;
                data_data_ok = 1'b0;
            end
        endcase
    end

    // Both requesters see the raw SRAM output. Each qualifies it with its
    // own data_ok.
    assign inst_rdata = sram_rdata;
    assign data_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    // Behavioural single-port SRAM: 256 words, byte writes, 1-cycle read.
    logic [31:0] mem [256];

    function automatic logic [31:0] init_word(input int unsigned idx);
        return (idx == 0) ? 32'h0280_0421 : (32'hA000_0000 + 32'(idx));
    endfunction

    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= mem[sram_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (sram_we[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd);
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wr    = dw;
        data_wstrb = ds;
        data_addr  = da;
        data_wdata = dd;
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [3:0]  ds;
        logic [31:0] da;
        logic [31:0] dd;
        logic        e_iaok;
        logic        e_daok;
        logic        e_idok;
        logic        e_ddok;
        logic        e_en;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        bit prev_i;
        bit prev_d;
        bit exp_i;

        for (int i = 0; i < 256; i++) mem[i] = init_word(i);

        // Directed vectors, one per cycle. The response columns refer to the
        // previous row's grant.
        //            ir ia            dr dw ds    da         dd            iaok daok idok ddok en we     addr          wdata         chk rd
        vecs[0] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h1c000000, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b1,1'b0,1'b0,1'b0,1'b1,4'h0, 32'h1c000000, 32'h0,        1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0,1'b0,1'b1,1'b0,1'b0,4'h0, 32'h0,        32'h0,        1'b1, 32'h02800421};
        vecs[3] = '{1'b0, 32'h0,        1'b1, 1'b1, 4'hf, 32'h100, 32'hdeadbeef,  1'b0,1'b1,1'b0,1'b0,1'b1,4'hf, 32'h100,      32'hdeadbeef, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'h0, 32'h100, 32'h0,         1'b0,1'b1,1'b0,1'b1,1'b1,4'h0, 32'h100,      32'h0,        1'b0, 32'h0};
        vecs[5] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0,1'b0,1'b0,1'b1,1'b0,4'h0, 32'h0,        32'h0,        1'b1, 32'hdeadbeef};
        vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b1, 4'h3, 32'h104, 32'h12345678,  1'b0,1'b1,1'b0,1'b0,1'b1,4'h3, 32'h104,      32'h12345678, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 32'h1c000000, 1'b0, 1'b1, 4'hf, 32'h0,   32'h0,         1'b1,1'b0,1'b0,1'b1,1'b1,4'h0, 32'h1c000000, 32'h0,        1'b0, 32'h0};
        vecs[8] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'h0, 32'h104, 32'h0,         1'b0,1'b1,1'b1,1'b0,1'b1,4'h0, 32'h104,      32'h0,        1'b1, 32'h02800421};
        vecs[9] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0,1'b0,1'b0,1'b1,1'b0,4'h0, 32'h0,        32'h0,        1'b1, 32'hA0005678};

        // Reset: outputs gated even with both requests asserted.
        resetn = 1'b0;
        drive(1'b1, 32'h1c000000, 1'b1, 1'b1, 4'hf, 32'h100, 32'h55);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst iaok", 32'(inst_addr_ok), 32'd0);
        chk("rst daok", 32'(data_addr_ok), 32'd0);
        chk("rst idok", 32'(inst_data_ok), 32'd0);
        chk("rst ddok", 32'(data_data_ok), 32'd0);
        chk("rst en",   32'(sram_en),      32'd0);
        chk("rst we",   32'(sram_we),      32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].ds, vecs[i].da, vecs[i].dd);
            @(negedge clk);
            chk($sformatf("v%0d iaok", i),  32'(inst_addr_ok), 32'(vecs[i].e_iaok));
            chk($sformatf("v%0d daok", i),  32'(data_addr_ok), 32'(vecs[i].e_daok));
            chk($sformatf("v%0d idok", i),  32'(inst_data_ok), 32'(vecs[i].e_idok));
            chk($sformatf("v%0d ddok", i),  32'(data_data_ok), 32'(vecs[i].e_ddok));
            chk($sformatf("v%0d en", i),    32'(sram_en),      32'(vecs[i].e_en));
            chk($sformatf("v%0d we", i),    32'(sram_we),      32'(vecs[i].e_we));
            chk($sformatf("v%0d addr", i),  sram_addr,         vecs[i].e_addr);
            chk($sformatf("v%0d wdata", i), sram_wdata,        vecs[i].e_wdata);
            if (vecs[i].chk_rd) begin
                if (vecs[i].e_idok) chk($sformatf("v%0d irdata", i), inst_rdata, vecs[i].e_rd);
                else                chk($sformatf("v%0d drdata", i), data_rdata, vecs[i].e_rd);
            end
            @(posedge clk); #1;
        end

        // Continuous contention: D,D,D,D,I,D,D,D,D,I.
        prev_i = 1'b0;
        prev_d = 1'b0;
        drive(1'b1, 32'h1c000000, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        for (int k = 0; k < 10; k++) begin
            exp_i = (k == 4) || (k == 9);
            @(negedge clk);
            chk($sformatf("cont%0d iaok", k), 32'(inst_addr_ok), 32'(exp_i));
            chk($sformatf("cont%0d daok", k), 32'(data_addr_ok), 32'(!exp_i));
            chk($sformatf("cont%0d we", k),   32'(sram_we),      32'd0);
            chk($sformatf("cont%0d addr", k), sram_addr, exp_i ? 32'h1c000000 : 32'h100);
            chk($sformatf("cont%0d idok", k), 32'(inst_data_ok), 32'(prev_i));
            chk($sformatf("cont%0d ddok", k), 32'(data_data_ok), 32'(prev_d));
            if (prev_i) chk($sformatf("cont%0d irdata", k), inst_rdata, 32'h02800421);
            if (prev_d) chk($sformatf("cont%0d drdata", k), data_rdata, 32'hdeadbeef);
            prev_i = exp_i;
            prev_d = !exp_i;
            @(posedge clk); #1;
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("cont tail idok", 32'(inst_data_ok), 32'd1);
        chk("cont tail ddok", 32'(data_data_ok), 32'd0);
        chk("cont tail irdata", inst_rdata, 32'h02800421);
        @(posedge clk); #1;

        // Back-to-back fetches with no bubbles.
        for (int k = 0; k < 9; k++) begin
            if (k < 8) drive(1'b1, 32'h1c000000 + 32'(4 * k), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            else       drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            if (k < 8) begin
                chk($sformatf("b2b%0d iaok", k), 32'(inst_addr_ok), 32'd1);
                chk($sformatf("b2b%0d addr", k), sram_addr, 32'h1c000000 + 32'(4 * k));
            end
            chk($sformatf("b2b%0d idok", k), 32'(inst_data_ok), 32'(k > 0));
            chk($sformatf("b2b%0d ddok", k), 32'(data_data_ok), 32'd0);
            if (k > 0) chk($sformatf("b2b%0d irdata", k), inst_rdata, init_word(k - 1));
            @(posedge clk); #1;
        end

        // Reset mid-operation. Three data wins build up the starvation
        // count, then reset lands while the third load is in flight.
        drive(1'b1, 32'h1c000000, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("pre%0d daok", k), 32'(data_addr_ok), 32'd1);
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        #1 resetn = 1'b0;
        drive(1'b1, 32'h1c000000, 1'b1, 1'b1, 4'hf, 32'h100, 32'h0);
        #1;
        chk("mid iaok", 32'(inst_addr_ok), 32'd0);
        chk("mid daok", 32'(data_addr_ok), 32'd0);
        chk("mid en",   32'(sram_en),      32'd0);
        chk("mid we",   32'(sram_we),      32'd0);
        @(posedge clk); #1;
        chk("mid ddok dropped", 32'(data_data_ok), 32'd0);
        chk("mid idok",         32'(inst_data_ok), 32'd0);
        drive(1'b1, 32'h1c000000, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        #2 resetn = 1'b1;
        // A cleared counter gives four data wins before the fetch.
        prev_i = 1'b0;
        prev_d = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_i = (k == 4);
            @(negedge clk);
            chk($sformatf("post%0d iaok", k), 32'(inst_addr_ok), 32'(exp_i));
            chk($sformatf("post%0d daok", k), 32'(data_addr_ok), 32'(!exp_i));
            chk($sformatf("post%0d ddok", k), 32'(data_data_ok), 32'(prev_d));
            chk($sformatf("post%0d idok", k), 32'(inst_data_ok), 32'(prev_i));
            prev_i = exp_i;
            prev_d = !exp_i;
            @(posedge clk); #1;
        end
        drive(1'b1, 32'h1c000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("post fetch iaok", 32'(inst_addr_ok), 32'd1);
        chk("post fetch en",   32'(sram_en),      32'd1);
        chk("post fetch we",   32'(sram_we),      32'd0);
        chk("post fetch addr", sram_addr,         32'h1c000000);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("post fetch idok",   32'(inst_data_ok), 32'd1);
        chk("post fetch ddok",   32'(data_data_ok), 32'd0);
        chk("post fetch irdata", inst_rdata,        32'h02800421);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
